// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: bridges the load/store unit to the single L1 data-cache port.
// It accepts one op per fire, holds it on a valid/ready request channel until
// the cache takes it, then waits for the response and reports load/store
// completion with the op's ROB tag. Only one request is outstanding at a time.
// A flush while an op is in flight lets it finish on the cache side but
// suppresses its completion pulse.
// Optional feature: define MEM_TIMEOUT_EN to abort a response wait after
// TIMEOUT_CYCLES cycles and pulse mem_error.

module lsu_mem_sequencer #(
    parameter int XLEN           = 32,
    parameter int ROB_TAG_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire_memory_op,
    input  logic                     memory_op_type,
    input  logic [XLEN-1:0]          memory_address,
    input  logic [XLEN-1:0]          memory_data,
    input  logic [ROB_TAG_WIDTH-1:0] memory_rob_tag,
    input  logic                     kill_mem_req,
    input  logic                     flush,
    output logic                     lsu_ready,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_rdata,
    output logic                     load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
    output logic [XLEN-1:0]          load_data,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
    output logic                     mem_error
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic squash;
    logic squash_next;

    logic                     op_we;
    logic [XLEN-1:0]          op_addr;
    logic [XLEN-1:0]          op_data;
    logic [ROB_TAG_WIDTH-1:0] op_tag;

    logic accept;
    logic load_done;
    logic store_done;
    logic timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_count;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // The request channel and LSU handshake are direct views of the current state;
    // the request fields come straight from the latched op so they stay stable.
    assign lsu_ready     = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_we    = op_we;
    assign mem_req_addr  = op_addr;
    assign mem_req_wdata = op_data;

    // Next-state and event decode; flush only marks the op as squashed so an
    // already-presented request is never withdrawn from the cache.
    always_comb begin
        state_next  = state;
        squash_next = squash;
        accept      = 1'b0;
        load_done   = 1'b0;
        store_done  = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (fire_memory_op && !kill_mem_req && !flush) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    squash_next = 1'b1;
                end
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    squash_next = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_next  = IDLE;
                    squash_next = 1'b0;
                    load_done   = !squash && !flush && !op_we;
                    store_done  = !squash && !flush && op_we;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_count == LAST_WAIT) begin
                    timeout     = 1'b1;
                    state_next  = IDLE;
                    squash_next = 1'b0;
                end
`endif
            end
            default: begin
                state_next  = IDLE;
                squash_next = 1'b0;
            end
        endcase
    end

    // State register and squash flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            squash <= 1'b0;
        end else begin
            state  <= state_next;
            squash <= squash_next;
        end
    end

    // Capture the fired op so the request fields hold until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_we   <= 1'b0;
            op_addr <= '0;
            op_data <= '0;
            op_tag  <= '0;
        end else if (accept) begin
            op_we   <= memory_op_type;
            op_addr <= memory_address;
            op_data <= memory_data;
            op_tag  <= memory_rob_tag;
        end
    end

    // Completion pulses last one cycle; tag and data hold their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_succeeded          <= 1'b0;
            load_succeeded_rob_tag  <= '0;
            load_data               <= '0;
            store_succeeded         <= 1'b0;
            store_succeeded_rob_tag <= '0;
            mem_error               <= 1'b0;
        end else begin
            load_succeeded  <= load_done;
            store_succeeded <= store_done;
            mem_error       <= timeout;
            if (load_done) begin
                load_succeeded_rob_tag <= op_tag;
                load_data              <= mem_resp_rdata;
            end
            if (store_done) begin
                store_succeeded_rob_tag <= op_tag;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Response-wait counter: zero on the first WAIT cycle, counts up while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if (state != WAIT) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: directed scenarios followed by random traffic, with
// every DUT output compared each cycle against an op-lifecycle reference model.

module tb_lsu_mem_sequencer;

    localparam int XLEN = 32;
    localparam int TW   = 32;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            fire_memory_op;
    logic            memory_op_type;
    logic [XLEN-1:0] memory_address;
    logic [XLEN-1:0] memory_data;
    logic [TW-1:0]   memory_rob_tag;
    logic            kill_mem_req;
    logic            flush;
    logic            lsu_ready;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_rdata;
    logic            load_succeeded;
    logic [TW-1:0]   load_succeeded_rob_tag;
    logic [XLEN-1:0] load_data;
    logic            store_succeeded;
    logic [TW-1:0]   store_succeeded_rob_tag;
    logic            mem_error;

    int errors = 0;
    int checks = 0;

    // Reference model: one in-flight op and its progress, plus expected outputs.
    bit            m_busy;
    bit            m_sent;
    bit            m_squash;
    bit            m_we;
    logic [31:0]   m_addr;
    logic [31:0]   m_data;
    logic [31:0]   m_tag;
    int            m_cnt;
    bit            exp_ld;
    bit            exp_st;
    bit            exp_err;
    logic [31:0]   exp_ld_tag;
    logic [31:0]   exp_ld_data;
    logic [31:0]   exp_st_tag;

    lsu_mem_sequencer #(
        .XLEN(XLEN),
        .ROB_TAG_WIDTH(TW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fire_memory_op(fire_memory_op),
        .memory_op_type(memory_op_type),
        .memory_address(memory_address),
        .memory_data(memory_data),
        .memory_rob_tag(memory_rob_tag),
        .kill_mem_req(kill_mem_req),
        .flush(flush),
        .lsu_ready(lsu_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .load_succeeded(load_succeeded),
        .load_succeeded_rob_tag(load_succeeded_rob_tag),
        .load_data(load_data),
        .store_succeeded(store_succeeded),
        .store_succeeded_rob_tag(store_succeeded_rob_tag),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy      = 0;
        m_sent      = 0;
        m_squash    = 0;
        m_we        = 0;
        m_addr      = '0;
        m_data      = '0;
        m_tag       = '0;
        m_cnt       = 0;
        exp_ld      = 0;
        exp_st      = 0;
        exp_err     = 0;
        exp_ld_tag  = '0;
        exp_ld_data = '0;
        exp_st_tag  = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        if (reset) begin
            modelReset();
            return;
        end
        exp_ld  = 0;
        exp_st  = 0;
        exp_err = 0;
        if (!m_busy) begin
            if (fire_memory_op && !kill_mem_req && !flush) begin
                m_busy   = 1;
                m_sent   = 0;
                m_squash = 0;
                m_we     = memory_op_type;
                m_addr   = memory_address;
                m_data   = memory_data;
                m_tag    = memory_rob_tag;
            end
        end else if (!m_sent) begin
            if (flush) m_squash = 1;
            if (mem_req_ready) begin
                m_sent = 1;
                m_cnt  = 0;
            end
        end else begin
            if (flush) m_squash = 1;
            if (mem_resp_valid) begin
                if (!m_squash && !m_we) begin
                    exp_ld      = 1;
                    exp_ld_tag  = m_tag;
                    exp_ld_data = mem_resp_rdata;
                end
                if (!m_squash && m_we) begin
                    exp_st     = 1;
                    exp_st_tag = m_tag;
                end
                m_busy   = 0;
                m_squash = 0;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_cnt == TO - 1) begin
                exp_err  = 1;
                m_busy   = 0;
                m_squash = 0;
            end else begin
                m_cnt++;
            end
`endif
        end
    endtask

    task automatic checkOutput();
        bit exp_valid;
        exp_valid = m_busy && !m_sent;
        check("lsu_ready", 32'(lsu_ready), 32'(!m_busy));
        check("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("mem_req_we", 32'(mem_req_we), 32'(m_we));
            check("mem_req_addr", mem_req_addr, m_addr);
            check("mem_req_wdata", mem_req_wdata, m_data);
        end
        check("load_succeeded", 32'(load_succeeded), 32'(exp_ld));
        check("load_tag", load_succeeded_rob_tag, exp_ld_tag);
        check("load_data", load_data, exp_ld_data);
        check("store_succeeded", 32'(store_succeeded), 32'(exp_st));
        check("store_tag", store_succeeded_rob_tag, exp_st_tag);
        check("mem_error", 32'(mem_error), 32'(exp_err));
    endtask

    // One clock: check the settled outputs, drive new inputs, step the model.
    task automatic applyStimulus(input logic rst, input logic f, input logic ty,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] t, input logic k, input logic fl,
                                 input logic rdy, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        checkOutput();
        reset          = rst;
        fire_memory_op = f;
        memory_op_type = ty;
        memory_address = a;
        memory_data    = d;
        memory_rob_tag = t;
        kill_mem_req   = k;
        flush          = fl;
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_rdata = rd;
        modelStep();
        @(posedge clk);
    endtask

    task automatic doFire(input logic ty, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] t, input logic k);
        applyStimulus(0, 1, ty, a, d, t, k, 0, 0, 0, 32'h0);
    endtask

    task automatic doCycle(input logic rdy, input logic rv, input logic [31:0] rd,
                           input logic fl, input logic rst);
        applyStimulus(rst, 0, 0, 32'h0, 32'h0, 32'h0, 0, fl, rdy, rv, rd);
    endtask

    initial begin
        reset          = 1'b1;
        fire_memory_op = 1'b0;
        memory_op_type = 1'b0;
        memory_address = '0;
        memory_data    = '0;
        memory_rob_tag = '0;
        kill_mem_req   = 1'b0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        modelReset();

        // Load happy path.
        doFire(0, 32'h100, 32'h0, 32'd5, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'hDEADBEEF, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);

        // Store with three cycles of backpressure.
        doFire(1, 32'h200, 32'h1234, 32'd9, 0);
        doCycle(0, 0, 32'h0, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h55AA55AA, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);

        // Killed fire, then an immediate accepted fire.
        doFire(0, 32'h300, 32'h0, 32'd7, 1);
        doFire(0, 32'h304, 32'h0, 32'd3, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'hCAFEF00D, 0, 0);

        // Back-to-back fire on the cycle the previous op returns to idle.
        doFire(1, 32'h308, 32'h77, 32'd4, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h0, 0, 0);
        doFire(0, 32'h30C, 32'h0, 32'd6, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h0BADC0DE, 0, 0);

        // Flush during WAIT, then flush coincident with the response.
        doFire(0, 32'h400, 32'h0, 32'd11, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 0, 32'h0, 1, 0);
        doCycle(0, 1, 32'h11111111, 0, 0);
        doFire(1, 32'h404, 32'h99, 32'd12, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h0, 1, 0);
        doCycle(0, 0, 32'h0, 0, 0);

        // Flush in REQ: request still completes but no pulse.
        doFire(0, 32'h408, 32'h0, 32'd14, 0);
        doCycle(0, 0, 32'h0, 1, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h22222222, 0, 0);

        // Reset while in REQ; a later response must be ignored.
        doFire(0, 32'h500, 32'h0, 32'd13, 0);
        doCycle(0, 0, 32'h0, 0, 1);
        doCycle(1, 1, 32'h33333333, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);

`ifdef MEM_TIMEOUT_EN
        // Response never arrives; a late response after the timeout is ignored.
        doFire(0, 32'h600, 32'h0, 32'd21, 0);
        doCycle(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < TO + 2; i++) doCycle(0, 0, 32'h0, 0, 0);
        doCycle(0, 1, 32'h44444444, 0, 0);
        doCycle(0, 0, 32'h0, 0, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom, $urandom, $urandom,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0,
                          $urandom);
        end

        @(negedge clk);
        checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
